// File: rtl/deadtime_gen.sv
// Complementary half-bridge gate driver with programmable dead time, latched fault
// shutdown and a completed high-pulse counter for register readback.
module deadtime_gen #(
    parameter int DT_W   = 16,
    parameter int DT_MIN = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             pwm_in,
    input  logic [DT_W-1:0]  dead_time,
    input  logic             fault,
    input  logic             fault_clr,
    output logic             gate_hi,
    output logic             gate_lo,
    output logic             fault_latched,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] pulse_cnt
);

    typedef enum logic [2:0] {
        OFF   = 3'd0,
        DT_HI = 3'd1,
        HI_ON = 3'd2,
        DT_LO = 3'd3,
        LO_ON = 3'd4
    } state_t;

    state_t          cur;
    state_t          nxt;
    logic [DT_W-1:0] cnt;
    logic [DT_W-1:0] dte;
    logic            band_done;
    logic            in_band_next;
    logic            band_entry;

    assign state = cur;

    always_comb begin
        dte = (dead_time < DT_W'(DT_MIN)) ? DT_W'(DT_MIN) : dead_time;
    end

    // cnt <= 1 rather than == 1 so a band can never stall on a zero count
    assign band_done = (cnt <= DT_W'(1));

    always_comb begin
        nxt = OFF;
        if (fault || fault_latched) begin
            nxt = OFF;
        end else if (!en) begin
            nxt = OFF;
        end else begin
            case (cur)
                OFF:     nxt = pwm_in ? DT_HI : DT_LO;
                DT_HI:   nxt = !pwm_in ? LO_ON : (band_done ? HI_ON : DT_HI);
                HI_ON:   nxt = pwm_in ? HI_ON : DT_LO;
                DT_LO:   nxt = pwm_in ? HI_ON : (band_done ? LO_ON : DT_LO);
                LO_ON:   nxt = pwm_in ? DT_HI : LO_ON;
                default: nxt = OFF;
            endcase
        end
    end

    assign in_band_next = (nxt == DT_HI) || (nxt == DT_LO);
    assign band_entry   = in_band_next && (nxt != cur);

    // Gates decode from the next state, so both are registered and mutually exclusive.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cur           <= OFF;
            gate_hi       <= 1'b0;
            gate_lo       <= 1'b0;
            fault_latched <= 1'b0;
            pulse_cnt     <= '0;
            cnt           <= '0;
        end else begin
            cur     <= nxt;
            gate_hi <= (nxt == HI_ON);
            gate_lo <= (nxt == LO_ON);

            if (fault) begin
                fault_latched <= 1'b1;
            end else if (fault_clr) begin
                fault_latched <= 1'b0;
            end

            if (band_entry) begin
                cnt <= dte;
            end else if (in_band_next) begin
                cnt <= cnt - DT_W'(1);
            end else begin
                cnt <= '0;
            end

            if ((cur == HI_ON) && (nxt == DT_LO)) begin
                pulse_cnt <= pulse_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_deadtime_gen.sv
// Directed checks of dead-band timing, glitch rejection, fault latch and reset,
// followed by a randomized overlap/reset sweep.
module tb_deadtime_gen;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic        pwm_in;
    logic [15:0] dead_time;
    logic        fault;
    logic        fault_clr;
    logic        gate_hi;
    logic        gate_lo;
    logic        fault_latched;
    logic [2:0]  state;
    logic [15:0] pulse_cnt;

    int checks   = 0;
    int failures = 0;

    deadtime_gen #(.DT_W(16), .DT_MIN(4), .CNT_W(16)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .en            (en),
        .pwm_in        (pwm_in),
        .dead_time     (dead_time),
        .fault         (fault),
        .fault_clr     (fault_clr),
        .gate_hi       (gate_hi),
        .gate_lo       (gate_lo),
        .fault_latched (fault_latched),
        .state         (state),
        .pulse_cnt     (pulse_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // n cycles of dead band in state st (both gates low), dead_time rewritten mid-band
    task automatic band(input logic [2:0] st, input int n, input logic [15:0] mid_dt);
        for (int i = 0; i < n; i++) begin
            if (i == 2) dead_time = mid_dt;
            cyc();
            chk("band_state", 32'(state), 32'(st));
            chk("band_gates", {30'd0, gate_hi, gate_lo}, 32'd0);
        end
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0; pwm_in = 1'b0; dead_time = 16'd10;
        fault = 1'b0; fault_clr = 1'b0;
        cyc(); cyc();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_gates", {30'd0, gate_hi, gate_lo}, 32'd0);
        chk("rst_fault", 32'(fault_latched), 32'd0);
        chk("rst_pcnt", 32'(pulse_cnt), 32'd0);

        // startup: OFF -> DT_LO for 10 cycles -> LO_ON
        rstn = 1'b1; en = 1'b1;
        band(3'd3, 10, 16'd10);
        cyc();
        chk("start_lo_state", 32'(state), 32'd4);
        chk("start_lo_gate", {30'd0, gate_hi, gate_lo}, 32'd1);

        // rising edge: dead band of 10 even though dead_time changes mid-band
        pwm_in = 1'b1;
        band(3'd1, 10, 16'd20);
        cyc();
        chk("hi_on_state", 32'(state), 32'd2);
        chk("hi_on_gate", {30'd0, gate_hi, gate_lo}, 32'd2);
        pwm_in = 1'b0;
        band(3'd3, 20, 16'd20);
        cyc();
        chk("lo_on_gate", {30'd0, gate_hi, gate_lo}, 32'd1);
        chk("pcnt_1", 32'(pulse_cnt), 32'd1);

        // dead_time below floor clamps to DT_MIN=4
        dead_time = 16'd1;
        pwm_in = 1'b1;
        band(3'd1, 4, 16'd1);
        cyc();
        chk("min_hi_gate", {30'd0, gate_hi, gate_lo}, 32'd2);
        pwm_in = 1'b0;
        band(3'd3, 4, 16'd0);
        cyc();
        chk("min_lo_gate", {30'd0, gate_hi, gate_lo}, 32'd1);
        chk("pcnt_2", 32'(pulse_cnt), 32'd2);

        // 3-cycle glitch never reaches gate_hi
        dead_time = 16'd10;
        pwm_in = 1'b1;
        band(3'd1, 3, 16'd10);
        pwm_in = 1'b0;
        cyc();
        chk("glitch_state", 32'(state), 32'd4);
        chk("glitch_gate", {30'd0, gate_hi, gate_lo}, 32'd1);
        chk("glitch_pcnt", 32'(pulse_cnt), 32'd2);

        // fault while HI_ON
        pwm_in = 1'b1;
        band(3'd1, 10, 16'd10);
        cyc();
        chk("pre_fault_hi", {30'd0, gate_hi, gate_lo}, 32'd2);
        fault = 1'b1;
        cyc();
        chk("fault_gates", {30'd0, gate_hi, gate_lo}, 32'd0);
        chk("fault_state", 32'(state), 32'd0);
        chk("fault_flag", 32'(fault_latched), 32'd1);
        fault_clr = 1'b1;
        cyc();
        chk("fault_wins_clr", 32'(fault_latched), 32'd1);
        fault = 1'b0; fault_clr = 1'b0;
        cyc();
        chk("fault_sticky", 32'(fault_latched), 32'd1);
        chk("fault_hold_off", 32'(state), 32'd0);
        fault_clr = 1'b1;
        cyc();
        fault_clr = 1'b0;
        chk("fault_cleared", 32'(fault_latched), 32'd0);
        chk("clr_cycle_off", 32'(state), 32'd0);
        band(3'd1, 10, 16'd10);
        cyc();
        chk("resume_hi", {30'd0, gate_hi, gate_lo}, 32'd2);
        chk("fault_no_pcnt", 32'(pulse_cnt), 32'd2);

        // en=0 exit from HI_ON does not count
        en = 1'b0;
        cyc();
        chk("dis_state", 32'(state), 32'd0);
        chk("dis_gates", {30'd0, gate_hi, gate_lo}, 32'd0);
        chk("dis_pcnt", 32'(pulse_cnt), 32'd2);

        // reset in the middle of a band
        en = 1'b1; pwm_in = 1'b0;
        band(3'd3, 2, 16'd10);
        rstn = 1'b0;
        cyc();
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_gates", {30'd0, gate_hi, gate_lo}, 32'd0);
        chk("midrst_pcnt", 32'(pulse_cnt), 32'd0);
        rstn = 1'b1;

        // randomized sweep: no overlap, gates low after every reset
        for (int i = 0; i < 3000; i++) begin
            pwm_in    = ($urandom_range(0, 7) < 4);
            en        = ($urandom_range(0, 31) != 0);
            dead_time = 16'($urandom_range(0, 12));
            rstn      = ($urandom_range(0, 63) != 0);
            cyc();
            chk("rand_overlap", 32'(gate_hi & gate_lo), 32'd0);
            if (!rstn) chk("rand_rst_gates", {30'd0, gate_hi, gate_lo}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
